// File: rtl/da_sample_tx.sv
`default_nettype none
// ============================================================================
//  Module   : da_sample_tx
//  Purpose  : Paced sample transmitter for the parallel DAC path. Samples come
//             in on a valid/ready stream and are buffered in a small FIFO.
//             They leave on the DAC bus at one sample every RATE_DIV clocks,
//             together with a generated DAC latch clock. If the FIFO is empty
//             at a sample slot, the bus holds its last value and a saturating
//             underflow counter is incremented.
//
//  Ports    : clk            system clock (PLL output)
//             rst_n          asynchronous active-low reset
//             pattern_sel    (only with DA_TX_TEST_PATTERN_EN) send the ramp
//                            instead of FIFO data
//             en             enables pacing and the DAC clock
//             s_data/s_valid/s_ready   input sample stream
//             da_data        registered DAC data bus
//             da_clk         registered DAC latch clock (DAC latches on rise)
//             level          FIFO occupancy
//             underflow_cnt  saturating count of missed samples
//
//  Options  : `define DA_TX_TEST_PATTERN_EN to add the pattern_sel input and
//             the internal ramp generator.
//
//  Revision : 1.0  initial release
// ============================================================================
module da_sample_tx #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int RATE_DIV   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
`ifdef DA_TX_TEST_PATTERN_EN
   input  logic                          pattern_sel,
`endif
   input  logic                          en,
   input  logic [DATA_W-1:0]             s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic [DATA_W-1:0]             da_data,
   output logic                          da_clk,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic [15:0]                   underflow_cnt
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int DIV_W  = $clog2(RATE_DIV);

   localparam logic [DIV_W-1:0]  c_div_last = DIV_W'(RATE_DIV - 1);
   localparam logic [DIV_W-1:0]  c_div_half = DIV_W'(RATE_DIV / 2);
   localparam logic [LVL_W-1:0]  c_lvl_full = LVL_W'(FIFO_DEPTH);
   localparam logic [DATA_W-1:0] c_midscale = DATA_W'(1) << (DATA_W - 1);
   localparam logic [15:0]       c_uf_max   = 16'hFFFF;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic [DIV_W-1:0]  r_div_cnt;
   logic              r_da_clk;
   logic [DATA_W-1:0] r_da_data;
   logic [15:0]       r_underflow_cnt;

   logic [DIV_W-1:0]  w_div_next;
   logic              w_strobe;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_underflow;
   logic              w_fifo_sel;

   // ------------------------------------------------------------------------
   // Handshake and FIFO status, decoded from registered occupancy only
   // ------------------------------------------------------------------------
   assign w_empty = (r_level == '0);
   assign s_ready = (r_level != c_lvl_full);
   assign w_push  = s_valid && s_ready;

   // ------------------------------------------------------------------------
   // Divider: one strobe per RATE_DIV clocks while enabled
   // ------------------------------------------------------------------------
   assign w_strobe = en && (r_div_cnt == c_div_last);

   always_comb begin
      w_div_next = '0;
      if (en && (r_div_cnt != c_div_last)) begin
         w_div_next = r_div_cnt + 1'b1;
      end
   end

`ifdef DA_TX_TEST_PATTERN_EN
   // While the ramp is selected the FIFO is left untouched.
   assign w_fifo_sel = !pattern_sel;
`else
   assign w_fifo_sel = 1'b1;
`endif

   // The strobe looks at the occupancy before any same-cycle push, so a
   // sample pushed into an empty FIFO on a strobe cycle waits for the next
   // slot and the current slot counts as an underflow.
   assign w_pop       = w_strobe && w_fifo_sel && !w_empty;
   assign w_underflow = w_strobe && w_fifo_sel &&  w_empty;

   // ------------------------------------------------------------------------
   // FIFO storage (contents need no reset; pointers define validity)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= s_data;
      end
   end

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Optional ramp generator
   // ------------------------------------------------------------------------
`ifdef DA_TX_TEST_PATTERN_EN
   logic [DATA_W-1:0] r_ramp;
   logic              w_ramp_strobe;

   assign w_ramp_strobe = w_strobe && pattern_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ramp <= '0;
      end else if (!en) begin
         r_ramp <= '0;
      end else if (w_ramp_strobe) begin
         r_ramp <= r_ramp + 1'b1;
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Pacing, DAC clock, output bus and underflow counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt       <= '0;
         r_da_clk        <= 1'b0;
         r_da_data       <= c_midscale;
         r_underflow_cnt <= '0;
      end else begin
         r_div_cnt <= w_div_next;

         // The clock is derived from the upcoming divider value so that it
         // is low in the first half of each period (when data changes) and
         // rises mid-period.
         r_da_clk  <= en && (w_div_next >= c_div_half);

         if (!en) begin
            r_da_data <= c_midscale;
         end else if (w_pop) begin
            r_da_data <= r_mem[r_rd_ptr];
`ifdef DA_TX_TEST_PATTERN_EN
         end else if (w_ramp_strobe) begin
            r_da_data <= r_ramp;
`endif
         end

         if (w_underflow && (r_underflow_cnt != c_uf_max)) begin
            r_underflow_cnt <= r_underflow_cnt + 1'b1;
         end
      end
   end

   assign da_data       = r_da_data;
   assign da_clk        = r_da_clk;
   assign level         = r_level;
   assign underflow_cnt = r_underflow_cnt;

endmodule
`default_nettype wire
